instr_issue_queue: RTL

//  Upstream feeder of the accelerator controller (the block that decodes 64-bit instructions).

---
 rtl/ctrl_pkg.sv | 29 ++
 rtl/instr_issue_queue_if.sv | 48 ++++
 rtl/instr_issue_queue_sync_fifo.sv | 66 ++++++
 rtl/instr_issue_queue.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the accelerator instruction path.
//   INSTR_W / OPC_LSB / OPC_W : 64-bit instruction word geometry (opcode in bits [4:0]).
//   OPC_*                     : opcode constants understood by the controller.
//   is_stream_op()            : 1 for opcodes that stream through the array (MAC, Send-weights).
package ctrl_pkg;

    localparam int unsigned INSTR_W = 64;
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_W   = 5;

    typedef logic [OPC_W-1:0] opc_t;

    localparam opc_t OPC_NONE    = 5'b00000;
    localparam opc_t OPC_MAC     = 5'b00001;
    localparam opc_t OPC_SEND_WT = 5'b00010;
    localparam opc_t OPC_STORE   = 5'b00011;
    localparam opc_t OPC_RX_INP  = 5'b00100;
    localparam opc_t OPC_RX_WT   = 5'b00101;
    localparam opc_t OPC_TX_OUT  = 5'b00110;
    localparam opc_t OPC_ACC_RST = 5'b00111;
    localparam opc_t OPC_NOP     = 5'b11111;

    function automatic logic is_stream_op(input logic [INSTR_W-1:0] word);
        opc_t opc;
        opc = word[OPC_LSB +: OPC_W];
        return (opc == OPC_MAC) || (opc == OPC_SEND_WT);
    endfunction

endpackage

// File: rtl/instr_issue_queue_if.sv
// instr_issue_queue_if: host-side and issue-side signals of the instruction issue queue.
//   host_instr  [63:0]  host -> queue   instruction word
//   host_valid          host -> queue   host_instr valid
//   host_ready          queue -> host   queue can accept (~full & ~flush)
//   flush               host -> queue   synchronous drop of queue contents / stall
//   instruction [63:0]  queue -> ctrl   registered instruction, zero when idle
//   issue_busy          queue -> ctrl   1 while the issuer is stalled behind a streaming op
//   fifo_count          queue -> host   occupancy 0..DEPTH
//   stat_issued/stat_stall (only with IIQ_STATS_EN): non-zero words issued / stall cycles
// modport master = host/environment side, modport slave = the queue.
interface instr_issue_queue_if #(
    parameter int unsigned DEPTH = 16
);
    import ctrl_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [INSTR_W-1:0] host_instr;
    logic               host_valid;
    logic               host_ready;
    logic               flush;
    logic [INSTR_W-1:0] instruction;
    logic               issue_busy;
    logic [CNT_W-1:0]   fifo_count;
`ifdef IIQ_STATS_EN
    logic [31:0]        stat_issued;
    logic [31:0]        stat_stall;

    modport master (
        output host_instr, host_valid, flush,
        input  host_ready, instruction, issue_busy, fifo_count, stat_issued, stat_stall
    );
    modport slave (
        input  host_instr, host_valid, flush,
        output host_ready, instruction, issue_busy, fifo_count, stat_issued, stat_stall
    );
`else
    modport master (
        output host_instr, host_valid, flush,
        input  host_ready, instruction, issue_busy, fifo_count
    );
    modport slave (
        input  host_instr, host_valid, flush,
        output host_ready, instruction, issue_busy, fifo_count
    );
`endif

endinterface

// File: rtl/instr_issue_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO storage for the issue queue.
//   clk, rst      clock, asynchronous active-high reset
//   i_clear       synchronous empty (wins over push/pop)
//   i_push/i_wdata write request; ignored when full, even if a pop happens in the same cycle
//   i_pop         read request; ignored when empty
//   o_rdata       head entry (combinational read)
//   o_full/o_empty/o_count  status, count is 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full & ~i_clear;
    assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/instr_issue_queue.sv
// instr_issue_queue: buffers 64-bit host instructions and issues at most one per cycle on a
// registered bus to the instruction decoder. After a streaming op (MAC, Send-weights) it
// inserts STREAM_CYCLES all-zero words while the array drains.
//   clk  clock (posedge)
//   rst  asynchronous active-high reset
//   bus  instr_issue_queue_if.slave: host_instr/host_valid/host_ready/flush in,
//        instruction/issue_busy/fifo_count out (+ stat_issued/stat_stall)
// Optional feature: define IIQ_STATS_EN to add the stat_issued / stat_stall counters.
module instr_issue_queue
    import ctrl_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned STREAM_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_issue_queue_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SC_W  = $clog2(STREAM_CYCLES + 1);

    typedef enum logic {
        StIssue,
        StStall
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [SC_W-1:0]    r_stall_cnt;
    logic [SC_W-1:0]    w_stall_cnt_next;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_next;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [INSTR_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_push;
    logic               w_pop;

    assign bus.host_ready = ~w_fifo_full & ~bus.flush;
    assign w_push         = bus.host_valid & bus.host_ready;
    assign w_pop          = (r_state == StIssue) & ~w_fifo_empty & ~bus.flush;

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.flush),
        .i_push  (w_push),
        .i_wdata (bus.host_instr),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_next     = r_state;
        w_stall_cnt_next = r_stall_cnt;
        w_instr_next     = '0;
        if (bus.flush) begin
            w_state_next     = StIssue;
            w_stall_cnt_next = '0;
        end else begin
            unique case (r_state)
                StIssue: begin
                    if (!w_fifo_empty) begin
                        w_instr_next = w_head;
                        if (is_stream_op(w_head)) begin
                            w_state_next     = StStall;
                            w_stall_cnt_next = SC_W'(STREAM_CYCLES);
                        end
                    end
                end
                StStall: begin
                    // Leaving at count 1 yields exactly STREAM_CYCLES zero words.
                    w_stall_cnt_next = r_stall_cnt - SC_W'(1);
                    if (r_stall_cnt == SC_W'(1)) begin
                        w_state_next = StIssue;
                    end
                end
                default: begin
                    w_state_next     = StIssue;
                    w_stall_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIssue;
            r_stall_cnt <= '0;
            r_instr     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_stall_cnt <= w_stall_cnt_next;
            r_instr     <= w_instr_next;
        end
    end

    assign bus.instruction = r_instr;
    assign bus.issue_busy  = (r_state == StStall);
    assign bus.fifo_count  = w_count;

`ifdef IIQ_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else if (bus.flush) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_instr_next != '0)  r_stat_issued <= r_stat_issued + 32'd1;
            if (r_state == StStall)  r_stat_stall  <= r_stat_stall + 32'd1;
        end
    end

    assign bus.stat_issued = r_stat_issued;
    assign bus.stat_stall  = r_stat_stall;
`endif

endmodule
